// File: rtl/dma_tx_pkg.sv
// Shared types and constants for the DMA transmit byte serializer.
package dma_tx_pkg;

  localparam int DEF_DWIDTH = 64;
  localparam int DEF_LWIDTH = 16;
  localparam int DEF_BYTES  = DEF_DWIDTH / 8;

  // Serializer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  // Packet descriptor as delivered by the descriptor logic; more fields may follow.
  typedef struct packed {
    logic [DEF_LWIDTH-1:0] len;
  } desc_t;

  // Width of a byte index within a word; at least one bit so single-byte words still index.
  function automatic int idx_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  localparam int DEF_IDXW = idx_width(DEF_BYTES);

endpackage

// File: rtl/axi_clks.sv
// Clock/reset bundle; rst is active-low.
interface AXI_clks;
  logic clk;
  logic rst;
  modport to_rtl (input clk, input rst);
endinterface

// File: rtl/dma_tx_byte_serializer.sv
// Pulls 64-bit words from a show-ahead FIFO and emits them little-endian as a
// valid/ready byte stream with SOP/EOP markers, one packet per length descriptor.
module dma_tx_byte_serializer
  import dma_tx_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int LWIDTH = DEF_LWIDTH
) (
  AXI_clks.to_rtl            clks,
  input  logic               len_valid,
  input  logic [LWIDTH-1:0]  len_data,
  output logic               len_ready,
  input  logic [DWIDTH-1:0]  fifo_data,
  input  logic               fifo_empty,
  output logic               fifo_pull,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_sop,
  output logic               tx_eop,
  output logic               underrun,
  output logic               zero_len
);

  localparam int BYTES = DWIDTH / 8;
  localparam int IDXW  = idx_width(BYTES);

  state_t              state_reg, state_next;
  logic [LWIDTH-1:0]   bytes_left_reg, bytes_left_next;
  logic [IDXW-1:0]     byte_idx_reg, byte_idx_next;
  logic                first_reg, first_next;
  logic [DWIDTH-1:0]   word_reg, word_next;
  logic                underrun_reg, underrun_next;
  logic                zero_len_reg, zero_len_next;
  // Held low through reset so len_ready only rises on the first edge after release.
  logic                run_reg;

  // Split the held word into byte lanes for the output mux.
  logic [7:0] word_bytes [BYTES];
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign word_bytes[gi] = word_reg[8*gi +: 8];
    end
  endgenerate

  assign underrun = underrun_reg;
  assign zero_len = zero_len_reg;

  // State and datapath registers.
  always_ff @(posedge clks.clk or negedge clks.rst) begin
    if (!clks.rst) begin
      state_reg      <= IDLE;
      bytes_left_reg <= '0;
      byte_idx_reg   <= '0;
      first_reg      <= 1'b0;
      word_reg       <= '0;
      underrun_reg   <= 1'b0;
      zero_len_reg   <= 1'b0;
      run_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bytes_left_reg <= bytes_left_next;
      byte_idx_reg   <= byte_idx_next;
      first_reg      <= first_next;
      word_reg       <= word_next;
      underrun_reg   <= underrun_next;
      zero_len_reg   <= zero_len_next;
      run_reg        <= 1'b1;
    end
  end

  // Next-state, FIFO pop and byte-stream outputs.
  always_comb begin
    state_next      = state_reg;
    bytes_left_next = bytes_left_reg;
    byte_idx_next   = byte_idx_reg;
    first_next      = first_reg;
    word_next       = word_reg;
    underrun_next   = underrun_reg;
    zero_len_next   = 1'b0;
    len_ready       = 1'b0;
    fifo_pull       = 1'b0;
    tx_valid        = 1'b0;
    tx_data         = 8'h00;
    tx_sop          = 1'b0;
    tx_eop          = 1'b0;
    case (state_reg)
      IDLE: begin
        len_ready = run_reg;
        if (len_valid && run_reg) begin
          if (len_data == '0) begin
            zero_len_next = 1'b1;
          end else begin
            bytes_left_next = len_data;
            first_next      = 1'b1;
            state_next      = LOAD;
          end
        end
      end
      LOAD: begin
        if (!fifo_empty) begin
          word_next     = fifo_data;
          fifo_pull     = 1'b1;
          byte_idx_next = '0;
          state_next    = SEND;
        end else if (!first_reg) begin
          // Starving at a packet start is normal; starving mid-packet is not.
          underrun_next = 1'b1;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = word_bytes[byte_idx_reg];
        tx_sop   = first_reg;
        tx_eop   = (bytes_left_reg == LWIDTH'(1));
        if (tx_ready) begin
          bytes_left_next = bytes_left_reg - LWIDTH'(1);
          byte_idx_next   = byte_idx_reg + IDXW'(1);
          first_next      = 1'b0;
          if (bytes_left_reg == LWIDTH'(1)) begin
            // Tail bytes of the current word are dropped; it is already popped.
            state_next = IDLE;
          end else if (byte_idx_reg == IDXW'(BYTES - 1)) begin
            if (!fifo_empty) begin
              word_next     = fifo_data;
              fifo_pull     = 1'b1;
              byte_idx_next = '0;
            end else begin
              state_next = LOAD;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifndef SYNTHESIS
  a_no_pull_when_empty : assert property (@(posedge clks.clk) disable iff (!clks.rst)
    !(fifo_pull && fifo_empty));
  a_no_valid_in_idle : assert property (@(posedge clks.clk) disable iff (!clks.rst)
    !(tx_valid && state_reg == IDLE));
  a_hold_when_stalled : assert property (@(posedge clks.clk) disable iff (!clks.rst)
    (tx_valid && !tx_ready) |=> ($stable(tx_data) && $stable(tx_sop) && $stable(tx_eop)));
`endif

endmodule
